// File: rtl/synth_harness_driver.sv
// LFSR-driven stimulus/response sequencer for the synthesis harness.
// Optional signature register enabled by HARNESS_DRIVER_SIG_EN.
module synth_harness_driver #(
  parameter int          IN_WIDTH = 32,
  parameter int          LATENCY  = 2,
  parameter int          ITERS    = 16,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pin_in,
  output logic        pin_valid,
  output logic        pin_capture,
  input  logic        pin_out,
  output logic [15:0] signature
);

  localparam int BW = $clog2(IN_WIDTH + 1);
  localparam int WW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam int IW = $clog2(ITERS + 1);

  localparam logic [15:0]   SEED_EFF  = (SEED == 16'h0) ? 16'h0001 : SEED;
  localparam logic [BW-1:0] BIT_LAST  = BW'(IN_WIDTH - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [IW-1:0] ITER_LAST = IW'(ITERS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_SAMPLE
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] wait_cnt;
  logic [IW-1:0] iter_cnt;

  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // lfsr always holds the bit being presented, so pin_in can be
  // registered alongside pin_valid without a one-cycle skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pin_in      <= 1'b0;
      pin_valid   <= 1'b0;
      pin_capture <= 1'b0;
      lfsr        <= SEED_EFF;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      iter_cnt    <= '0;
    end else begin
      pin_in      <= 1'b0;
      pin_valid   <= 1'b0;
      pin_capture <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SHIFT;
            busy      <= 1'b1;
            done      <= 1'b0;
            lfsr      <= SEED_EFF;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            iter_cnt  <= '0;
            pin_valid <= 1'b1;
            pin_in    <= SEED_EFF[0];
          end
        end
        S_SHIFT: begin
          lfsr <= lfsr_nxt;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
            if (LATENCY == 0) begin
              state       <= S_CAPTURE;
              pin_capture <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            bit_cnt   <= bit_cnt + BW'(1);
            pin_valid <= 1'b1;
            pin_in    <= lfsr_nxt[0];
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt    <= '0;
            state       <= S_CAPTURE;
            pin_capture <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_CAPTURE: begin
          state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          iter_cnt <= iter_cnt + IW'(1);
          if (iter_cnt == ITER_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= S_SHIFT;
            pin_valid <= 1'b1;
            pin_in    <= lfsr[0];
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HARNESS_DRIVER_SIG_EN
  logic [15:0] sig;

  // CRC-CCITT style fold of one parity bit per iteration
  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= 16'h0000;
    end else if (state == S_IDLE && start) begin
      sig <= 16'h0000;
    end else if (state == S_SAMPLE) begin
      sig <= {sig[14:0], 1'b0}
           ^ (sig[15] ? 16'h1021 : 16'h0000)
           ^ {15'b0, pin_out};
    end
  end

  assign signature = sig;
`else
  logic unused_pin_out;
  assign unused_pin_out = pin_out;
  assign signature      = 16'h0000;
`endif

endmodule

// File: tb/tb_synth_harness_driver.sv
// Directed self-checking bench for synth_harness_driver.
// Covers default, short-latency and short-run configurations.
module tb_synth_harness_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_b = 1'b0;
  logic pin_out = 1'b0;

  logic        busy, done, pin_in, pin_valid, pin_capture;
  logic [15:0] signature;
  logic        b_busy, b_done, b_pin_in, b_pin_valid, b_pin_capture;
  logic [15:0] b_signature;
  logic        c_busy, c_done, c_pin_in, c_pin_valid, c_pin_capture;
  logic [15:0] c_signature;

  int checks = 0;
  int errors = 0;

`ifdef HARNESS_DRIVER_SIG_EN
  localparam logic [15:0] SIG1 = 16'h0001;
  localparam logic [15:0] SIG3 = 16'h0003;
`else
  localparam logic [15:0] SIG1 = 16'h0000;
  localparam logic [15:0] SIG3 = 16'h0000;
`endif

  always #5 clk = ~clk;

  synth_harness_driver dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .pin_in(pin_in), .pin_valid(pin_valid),
    .pin_capture(pin_capture), .pin_out(pin_out),
    .signature(signature)
  );

  synth_harness_driver #(.ITERS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .busy(b_busy), .done(b_done),
    .pin_in(b_pin_in), .pin_valid(b_pin_valid),
    .pin_capture(b_pin_capture), .pin_out(1'b1),
    .signature(b_signature)
  );

  synth_harness_driver #(.IN_WIDTH(4), .LATENCY(0), .ITERS(2)) dut_c (
    .clk(clk), .rst(rst), .start(start_b),
    .busy(c_busy), .done(c_done),
    .pin_in(c_pin_in), .pin_valid(c_pin_valid),
    .pin_capture(c_pin_capture), .pin_out(1'b0),
    .signature(c_signature)
  );

  function automatic logic [15:0] model_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic start_main;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset;
    logic [20:0] o;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    o = {busy, done, pin_in, pin_valid, pin_capture, signature};
    checks++;
    if (o !== 21'h0) begin
      errors++; $display("FAIL reset_main got %0h want 0", o);
    end
    o = {b_busy, b_done, c_busy, c_done, b_pin_valid, c_pin_valid, b_signature};
    checks++;
    if (o !== 21'h0) begin
      errors++; $display("FAIL reset_bc got %0h want 0", o);
    end
    rst = 1'b0;
    @(negedge clk);
    o = {18'h0, busy, pin_valid, pin_capture};
    checks++;
    if (o !== 21'h0) begin
      errors++; $display("FAIL post_reset got %0h want 0", o);
    end
  endtask

  task automatic test_small;
    logic [16:1] cv, ccap, ev, ecap;
    int c_done_at, b_done_at;
    logic [15:0] b_sig37;
    cv = '0; ccap = '0; ev = '0; ecap = '0;
    c_done_at = 0; b_done_at = 0; b_sig37 = 16'hFFFF;
    @(negedge clk); start_b = 1'b1;
    for (int c = 1; c <= 73; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (c <= 16) begin
        cv[c]   = c_pin_valid;
        ccap[c] = c_pin_capture;
        ev[c]   = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
        ecap[c] = (c == 5) || (c == 11);
      end
      if (c_done && c_done_at == 0) c_done_at = c;
      if (b_done && b_done_at == 0) b_done_at = c;
      if (c == 37) b_sig37 = b_signature;
    end
    checks++;
    if (cv !== ev) begin
      errors++; $display("FAIL lat0_valid got %0h want %0h", cv, ev);
    end
    checks++;
    if (ccap !== ecap) begin
      errors++; $display("FAIL lat0_capture got %0h want %0h", ccap, ecap);
    end
    checks++;
    if (c_done_at != 13) begin
      errors++; $display("FAIL lat0_done_cycle got %0d want 13", c_done_at);
    end
    checks++;
    if (b_sig37 !== SIG1) begin
      errors++; $display("FAIL sig_iter1 got %0h want %0h", b_sig37, SIG1);
    end
    checks++;
    if (b_done_at != 73) begin
      errors++; $display("FAIL iters2_done_cycle got %0d want 73", b_done_at);
    end
    checks++;
    if (b_signature !== SIG3) begin
      errors++; $display("FAIL sig_iter2 got %0h want %0h", b_signature, SIG3);
    end
  endtask

  task automatic test_full_run;
    logic [5:0]  bits;
    logic [15:0] m;
    int vfirst, vlast, vcount, cap_first, cap_cnt;
    int bad_bits, bad_valid, bad_cap, nbits;
    logic b576, d576;
    logic ev, ecap;
    bits = '0; m = 16'hACE1;
    vfirst = 0; vlast = 0; vcount = 0; cap_first = 0; cap_cnt = 0;
    bad_bits = 0; bad_valid = 0; bad_cap = 0; nbits = 0;
    b576 = 1'b0; d576 = 1'b1;
    pin_out = 1'b0;
    start_main;
    for (int c = 1; c <= 577; c++) begin
      if (c > 1) @(negedge clk);
      ev   = (c <= 576) && (((c - 1) % 36) < 32);
      ecap = (c <= 576) && (((c - 1) % 36) == 34);
      if (pin_valid !== ev) bad_valid++;
      if (pin_capture !== ecap) bad_cap++;
      if (pin_valid) begin
        if (c <= 36) begin
          vcount++;
          if (vfirst == 0) vfirst = c;
          vlast = c;
        end
        if (c <= 6) bits = {bits[4:0], pin_in};
        if (pin_in !== m[0]) bad_bits++;
        m = model_step(m);
        nbits++;
      end
      if (pin_capture) begin
        cap_cnt++;
        if (cap_first == 0) cap_first = c;
      end
      if (c == 576) begin
        b576 = busy; d576 = done;
      end
    end
    checks++;
    if (vfirst != 1 || vlast != 32 || vcount != 32) begin
      errors++;
      $display("FAIL iter1_valid got %0d..%0d n=%0d want 1..32 n=32",
               vfirst, vlast, vcount);
    end
    checks++;
    if (bits !== 6'b100001) begin
      errors++; $display("FAIL first_bits got %b want 100001", bits);
    end
    checks++;
    if (cap_first != 35) begin
      errors++; $display("FAIL first_capture got %0d want 35", cap_first);
    end
    checks++;
    if (cap_cnt != 16 || bad_cap != 0) begin
      errors++;
      $display("FAIL capture_pattern got n=%0d bad=%0d want n=16 bad=0",
               cap_cnt, bad_cap);
    end
    checks++;
    if (bad_valid != 0) begin
      errors++; $display("FAIL valid_pattern got %0d bad cycles want 0", bad_valid);
    end
    checks++;
    if (bad_bits != 0 || nbits != 512) begin
      errors++;
      $display("FAIL lfsr_stream got bad=%0d n=%0d want bad=0 n=512",
               bad_bits, nbits);
    end
    checks++;
    if (b576 !== 1'b1 || d576 !== 1'b0) begin
      errors++; $display("FAIL pre_done got busy=%b done=%b want 1 0", b576, d576);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_577 got done=%b busy=%b want 1 0", done, busy);
    end
    checks++;
    if (signature !== 16'h0000) begin
      errors++; $display("FAIL sig_zero got %0h want 0", signature);
    end
  endtask

  task automatic test_reset_mid;
    logic [20:0] o;
    logic [15:0] m;
    int bad;
    start_main;
    for (int c = 2; c <= 105; c++) @(negedge clk);
    checks++;
    if ({busy, pin_valid, pin_capture} !== 3'b100) begin
      errors++;
      $display("FAIL wait_state got %b want 100", {busy, pin_valid, pin_capture});
    end
    rst = 1'b1;
    @(negedge clk);
    o = {busy, done, pin_in, pin_valid, pin_capture, signature};
    checks++;
    if (o !== 21'h0) begin
      errors++; $display("FAIL mid_reset got %0h want 0", o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, pin_valid, pin_capture} !== 3'b000) begin
      errors++;
      $display("FAIL after_mid_reset got %b want 000", {busy, pin_valid, pin_capture});
    end
    start_main;
    m = 16'hACE1; bad = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      if (pin_valid !== 1'b1 || pin_in !== m[0]) bad++;
      m = model_step(m);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL restart_stream got %0d bad bits want 0", bad);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_start_held;
    int done_cnt, busy_low;
    logic d577, b577, v577, v578;
    logic [5:0] bits;
    done_cnt = 0; busy_low = 0; bits = '0;
    d577 = 1'b0; b577 = 1'b1; v577 = 1'b1; v578 = 1'b0;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 584; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (c <= 576 && !busy) busy_low++;
      if (c == 577) begin
        d577 = done; b577 = busy; v577 = pin_valid;
      end
      if (c == 578) v578 = pin_valid;
      if (c >= 578 && c <= 583) bits = {bits[4:0], pin_in};
    end
    start = 1'b0;
    checks++;
    if (busy_low != 0) begin
      errors++; $display("FAIL held_busy got %0d idle cycles want 0", busy_low);
    end
    checks++;
    if (d577 !== 1'b1 || b577 !== 1'b0 || v577 !== 1'b0) begin
      errors++;
      $display("FAIL held_done got done=%b busy=%b valid=%b want 1 0 0",
               d577, b577, v577);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL held_done_width got %0d want 1", done_cnt);
    end
    checks++;
    if (v578 !== 1'b1 || bits !== 6'b100001) begin
      errors++;
      $display("FAIL held_restart got valid=%b bits=%b want 1 100001", v578, bits);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_small;
    test_full_run;
    test_reset_mid;
    test_start_held;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
